// File: rtl/quadrature_gen.sv
// Quadrature encoder emulator: turns (dir, steps) commands into a Gray-coded
// A/B waveform with a fixed hold time per phase and tracks a wrapping position.
module quadrature_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8,
  parameter int POS_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] pos
);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

  localparam logic [7:0] HLD = 8'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [7:0]       hold, hold_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             dir, dir_nxt;
  logic [1:0]       ab, ab_nxt;
  logic [POS_W-1:0] pos_r, pos_nxt;
  logic             done_r, done_nxt;
  logic             zpend, zpend_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hold   <= '0;
      rem    <= '0;
      dir    <= 1'b0;
      ab     <= 2'b00;
      pos_r  <= '0;
      done_r <= 1'b0;
      zpend  <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold   <= hold_nxt;
      rem    <= rem_nxt;
      dir    <= dir_nxt;
      ab     <= ab_nxt;
      pos_r  <= pos_nxt;
      done_r <= done_nxt;
      zpend  <= zpend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    rem_nxt   = rem;
    dir_nxt   = dir;
    ab_nxt    = ab;
    pos_nxt   = pos_r;
    done_nxt  = 1'b0;
    zpend_nxt = 1'b0;
    case (state)
      IDLE: begin
        // zero-step commands complete one cycle later without touching A/B
        done_nxt = zpend;
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            zpend_nxt = 1'b1;
          end else begin
            dir_nxt   = cmd_dir;
            rem_nxt   = cmd_steps;
            hold_nxt  = HLD;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (hold == '0) begin
          // CW: 00->10->11->01, CCW: 00->01->11->10
          ab_nxt   = dir ? {~ab[0], ab[1]} : {ab[0], ~ab[1]};
          pos_nxt  = dir ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
          rem_nxt  = rem - CNT_W'(1);
          hold_nxt = HLD;
          if (rem == CNT_W'(1)) state_nxt = SETTLE;
        end else begin
          hold_nxt = hold - 8'd1;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (hold == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          hold_nxt = hold - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign done      = done_r;
  assign A         = ab[1];
  assign B         = ab[0];
  assign pos       = pos_r;

endmodule

// File: doc/quadrature_gen.md
# quadrature_gen

Quadrature encoder emulator: converts step commands (direction + step count) into a two-phase A/B Gray-code waveform of the kind a 360° rotary encoder produces. It drives the team's quadrature decoder in loopback tests, and drives external stepper/encoder inputs on the board. It also keeps its own signed position count, so a bench can compare it with the decoder's count.

## Interface

Parameters:
- HOLD_CYCLES, default 4: clk cycles each A/B state is held before the next edge. Legal range 1..255.
- CNT_W, default 8: width of the step-count field of a command.
- POS_W, default 4: width of the position counter, which wraps modulo 2^POS_W.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block can accept a command. High only in IDLE.
- cmd_dir, input, 1: 1 = CW, 0 = CCW.
- cmd_steps, input, CNT_W: number of quadrature steps to emit. 0 is legal.
- abort, input, 1: stops the running command.
- A, output, 1: quadrature phase A, registered.
- B, output, 1: quadrature phase B, registered.
- busy, output, 1: equals !cmd_ready.
- done, output, 1: one-cycle pulse when a command completes normally.
- pos, output, POS_W: position. +1 per CW step, -1 per CCW step.

## Operation

- Phase encoding of {A,B}: P0=00, P1=01, P2=11, P3=10.
- CW sequence: P0→P3→P2→P1→P0, i.e. AB 00→10→11→01→00.
- CCW sequence: the reverse, P0→P1→P2→P3→P0.
- Each step is exactly one phase transition, so only one of A/B toggles per step.
- The phase persists across commands. It does not return to P0 at the end of a command.
- State machine:
  - IDLE: cmd_ready=1.
    - On cmd_valid with cmd_steps≠0: latch dir, set remaining=cmd_steps, load the hold counter with HOLD_CYCLES-1, go to RUN.
    - On cmd_valid with cmd_steps=0: pulse done the next cycle, stay in IDLE, leave A/B/pos unchanged.
  - RUN: the hold counter decrements every cycle.
    - When it reaches 0: advance the phase one step in dir, update pos by ±1, decrement remaining, reload the counter.
    - If remaining reaches 0 at that step: go to SETTLE.
  - SETTLE: hold the final phase for HOLD_CYCLES cycles, then go to IDLE and pulse done.
    - The decoder therefore sees the final state stable before the next command.
- cmd_valid is ignored while busy. The command is not queued.
- abort, sampled in RUN or SETTLE:
  - Next cycle the block is in IDLE.
  - A/B keep their current phase.
  - pos keeps its value.
  - No done pulse.
  - abort has no effect in IDLE.
- pos wraps modulo 2^POS_W: 2^POS_W-1 + 1 → 0, and 0 - 1 → 2^POS_W-1.
- Simultaneous abort and a step-due cycle: abort wins, and the step is not emitted.
- rst, at any time including mid-command:
  - Next cycle: state IDLE, A=0, B=0, pos=0, done=0, cmd_ready=1, busy=0, counters cleared.
  - The pending command is discarded.

## Timing

- Reset values: A=0, B=0, pos=0, done=0, cmd_ready=1, busy=0.
- Let a command be accepted at clock edge T (cmd_valid & cmd_ready sampled high).
  - busy is high from T+1.
  - Step k (k=1..N) changes A/B and pos at edge T+k·HOLD_CYCLES.
  - done is high, together with cmd_ready, during the cycle following edge T+(N+1)·HOLD_CYCLES.
- A new command may be accepted in the same cycle that done is high.
- Zero-step command accepted at T: done is high in the cycle after edge T+1, and cmd_ready stays high throughout.
- abort sampled at edge T: cmd_ready is high after T. No further A/B edge occurs.
- A, B and pos change on the same edge. done is never high while busy.
- Minimum A/B edge spacing is HOLD_CYCLES clk cycles. With HOLD_CYCLES=1, one edge per cycle.

## Test plan

- Reset: assert rst for 2 cycles mid-RUN → A=0, B=0, pos=0, cmd_ready=1, busy=0, done=0 on the next cycle, and no A/B edges afterwards.
- CW 4 steps, HOLD_CYCLES=4, accepted at T → AB=10/11/01/00 at T+4/8/12/16, pos=1/2/3/4, one done pulse after T+20, busy low after it.
- CCW 3 steps from reset → AB=01/11/10, pos=15/14/13 (POS_W=4), done after T+16. A following CW 1 step → AB=11, pos=14.
- Zero steps → done high exactly one cycle after acceptance, and A/B/pos unchanged. A cmd_valid pulse while busy (steps=5) → no effect on the step count or pos.
- Wrap: CW 20 steps from reset → pos=4, AB=00, exactly 20 single-bit A/B transitions, and never both bits toggling in one cycle.
- Abort after the 2nd step of a CW 6-step command → AB=11 frozen, pos=2, no done, cmd_ready=1 next cycle. In loopback, the decoder count equals pos after every scenario.
